vip_projection_bounds: RTL

//  Parametrised binary-image projection engine for plate/character localisation.

---
 rtl/vip_proj_pkg.sv | 31 +++
 rtl/vip_proj_ram.sv | 36 +++
 rtl/vip_projection_bounds.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vip_proj_pkg.sv
// -----------------------------------------------------------------------------
// vip_proj_pkg
// Shared definitions for the projection-bounds engine:
//   state_e  : FSM states IDLE -> ACCUM -> SCAN -> DONE
//   MODE_ROW : bins indexed by y (row histogram)
//   MODE_COL : bins indexed by x (column histogram)
//   sat_add  : unsigned add clamped to a caller-supplied maximum
// -----------------------------------------------------------------------------
package vip_proj_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCAN  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic MODE_ROW = 1'b0;
   localparam logic MODE_COL = 1'b1;

   // Width-agnostic saturating add; callers cast operands to 32 bits and the
   // result back to their own width, passing their all-ones value as max.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      sat_add = (s > {1'b0, max}) ? max : s[31:0];
   endfunction

endpackage

// File: rtl/vip_proj_ram.sv
// -----------------------------------------------------------------------------
// vip_proj_ram
// Simple dual-port histogram RAM: one write port, one read port with a
// single registered read stage (data appears the clock after the address).
// Ports:
//   clk_i             clock
//   we_i/waddr_i/wdata_i  write strobe, address, data
//   raddr_i           read address
//   rdata_o           registered read data
// -----------------------------------------------------------------------------
module vip_proj_ram #(
   parameter int unsigned DEPTH  = 640,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 10
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vip_projection_bounds.sv
// -----------------------------------------------------------------------------
// vip_projection_bounds
// Binary-image projection engine. During the active frame it builds a per-row
// (cfg_mode=0) or per-column (cfg_mode=1) histogram of set pixels inside a
// window on the other axis, then scans the histogram during vertical blanking
// for the first and last bin whose count exceeds cfg_thresh.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cfg_mode/thresh/win_start/win_end  configuration, captured at vsync rise
//   per_frame_vsync/href/clken, per_img_bit   input pixel stream
//   post_frame_vsync/href/clken, post_img_bit input stream delayed 2 clk
//   bound_lo/bound_hi/bound_found  result of the last completed scan
//   bound_valid                    1-clk pulse when bound_* update
//   scan_abort                     1-clk pulse when vsync rose mid-scan
// Optional (macro VIP_PROJ_PEAK_EN):
//   peak_idx/peak_cnt              highest bin, lowest index on a tie
// -----------------------------------------------------------------------------
module vip_projection_bounds
   import vip_proj_pkg::*;
#(
   parameter int unsigned IMG_HDISP = 640,
   parameter int unsigned IMG_VDISP = 480,
   parameter int unsigned COORD_W   = 10,
   parameter int unsigned CNT_W     = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_mode,
   input  logic [CNT_W-1:0]   cfg_thresh,
   input  logic [COORD_W-1:0] cfg_win_start,
   input  logic [COORD_W-1:0] cfg_win_end,
   input  logic               per_frame_vsync,
   input  logic               per_frame_href,
   input  logic               per_frame_clken,
   input  logic               per_img_bit,
   output logic               post_frame_vsync,
   output logic               post_frame_href,
   output logic               post_frame_clken,
   output logic               post_img_bit,
   output logic [COORD_W-1:0] bound_lo,
   output logic [COORD_W-1:0] bound_hi,
   output logic               bound_found,
   output logic               bound_valid,
   output logic               scan_abort
`ifdef VIP_PROJ_PEAK_EN
   ,
   output logic [COORD_W-1:0] peak_idx,
   output logic [CNT_W-1:0]   peak_cnt
`endif
);

   localparam int unsigned DEPTH = (IMG_HDISP > IMG_VDISP) ? IMG_HDISP : IMG_VDISP;
   localparam int unsigned SA_W  = COORD_W + 1;
   localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMG_HDISP - 1);
   localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(IMG_VDISP - 1);
   localparam logic [SA_W-1:0]    N_ROW   = SA_W'(IMG_VDISP);
   localparam logic [SA_W-1:0]    N_COL   = SA_W'(IMG_HDISP);
   localparam logic [CNT_W-1:0]   CNT_MAX = '1;

   // ---------------- pass-through pipeline ----------------
   logic [3:0] pipe1_q, pipe2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pipe1_q <= '0;
         pipe2_q <= '0;
      end else begin
         pipe1_q <= {per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit};
         pipe2_q <= pipe1_q;
      end
   end

   assign {post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit} = pipe2_q;

   // ---------------- vsync edges and config capture ----------------
   // vs_q resets high so a reset taken mid-frame does not look like a new
   // frame start; the first valid frame is the one after the next real rise.
   logic vs_q, vs_rise, vs_fall;
   logic               mode_q;
   logic [CNT_W-1:0]   thr_q;
   logic [COORD_W-1:0] ws_q, we_q;

   assign vs_rise = per_frame_vsync & ~vs_q;
   assign vs_fall = ~per_frame_vsync & vs_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q   <= 1'b1;
         mode_q <= MODE_ROW;
         thr_q  <= '0;
         ws_q   <= '0;
         we_q   <= '0;
      end else begin
         vs_q <= per_frame_vsync;
         if (vs_rise) begin
            mode_q <= cfg_mode;
            thr_q  <= cfg_thresh;
            ws_q   <= cfg_win_start;
            we_q   <= cfg_win_end;
         end
      end
   end

   // ---------------- pixel coordinates ----------------
   logic [COORD_W-1:0] x_q, y_q;

   always_ff @(posedge clk) begin
      if (rst || vs_rise) begin
         x_q <= '0;
         y_q <= '0;
      end else if (per_frame_clken) begin
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + COORD_W'(1);
         end else begin
            x_q <= x_q + COORD_W'(1);
         end
      end
   end

   // ---------------- accumulation datapath ----------------
   state_e state_q, state_d;

   logic x_in, y_in, pix_add, accum_pix, row_end, row_we;
   logic [CNT_W-1:0] acc_q, acc_sum, col_sum;
   logic [CNT_W-1:0] ram_rdata, ram_wdata;
   logic [COORD_W-1:0] ram_waddr, ram_raddr;
   logic ram_we;

   assign x_in      = (x_q >= ws_q) && (x_q <= we_q);
   assign y_in      = (y_q >= ws_q) && (y_q <= we_q);
   assign pix_add   = per_img_bit & ((mode_q == MODE_COL) ? y_in : x_in);
   assign accum_pix = (state_q == ACCUM) && per_frame_clken;
   assign row_end   = (x_q == X_LAST);
   assign row_we    = accum_pix && (mode_q == MODE_ROW) && row_end && (y_q <= Y_LAST);
   assign acc_sum   = CNT_W'(sat_add(32'(acc_q), 32'(pix_add), 32'(CNT_MAX)));

   always_ff @(posedge clk) begin
      if (rst || vs_rise) begin
         acc_q <= '0;
      end else if (accum_pix && (mode_q == MODE_ROW)) begin
         acc_q <= row_end ? '0 : acc_sum;
      end
   end

   // Column mode is read-modify-write: the bin is read on the pixel clock and
   // the updated value written one clock later from these pending registers.
   logic               wp_q, wp_add_q, wp_clr_q;
   logic [COORD_W-1:0] wp_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q      <= 1'b0;
         wp_add_q  <= 1'b0;
         wp_clr_q  <= 1'b0;
         wp_addr_q <= '0;
      end else begin
         wp_q      <= accum_pix && (mode_q == MODE_COL);
         wp_add_q  <= pix_add;
         wp_clr_q  <= (y_q == '0);
         wp_addr_q <= x_q;
      end
   end

   assign col_sum = wp_clr_q ? CNT_W'(wp_add_q)
                             : CNT_W'(sat_add(32'(ram_rdata), 32'(wp_add_q), 32'(CNT_MAX)));

   // ---------------- scan control ----------------
   logic [SA_W-1:0]    sa_q, sa_d, scan_n;
   logic               rd_issue, rv_q, rd_hit, scan_last, abort;
   logic [COORD_W-1:0] ridx_q;
   logic               run_found_q, fin_found;
   logic [COORD_W-1:0] run_lo_q, run_hi_q, fin_lo, fin_hi;

   assign scan_n   = (mode_q == MODE_ROW) ? N_ROW : N_COL;
   assign rd_issue = (state_q == SCAN) && (sa_q < scan_n);
   assign rd_hit   = rv_q && (ram_rdata > thr_q);

   // Running result merged with the bin arriving this clock, so the final
   // scan cycle can register the complete answer directly into bound_*.
   assign fin_found = run_found_q | rd_hit;
   assign fin_lo    = (rd_hit && !run_found_q) ? ridx_q : run_lo_q;
   assign fin_hi    = rd_hit ? ridx_q : run_hi_q;

   assign ram_we    = (mode_q == MODE_ROW) ? row_we  : wp_q;
   assign ram_waddr = (mode_q == MODE_ROW) ? y_q     : wp_addr_q;
   assign ram_wdata = (mode_q == MODE_ROW) ? acc_sum : col_sum;
   assign ram_raddr = rd_issue ? sa_q[COORD_W-1:0] : x_q;

   vip_proj_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (COORD_W),
      .DATA_W (CNT_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      scan_last = 1'b0;
      abort     = 1'b0;
      case (state_q)
         IDLE: begin
            if (vs_rise) state_d = ACCUM;
         end
         ACCUM: begin
            if (vs_fall) begin
               state_d = SCAN;
               sa_d    = '0;
            end
         end
         SCAN: begin
            if (vs_rise) begin
               state_d = ACCUM;
               abort   = 1'b1;
            end else if (sa_q == scan_n) begin
               // last address was issued last clock; its data is in rd_hit now
               state_d   = DONE;
               scan_last = 1'b1;
            end else begin
               sa_d = sa_q + SA_W'(1);
            end
         end
         DONE: begin
            if (vs_rise) begin
               state_d = ACCUM;
               abort   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   logic               bound_found_q, bound_valid_q, scan_abort_q;
   logic [COORD_W-1:0] bound_lo_q, bound_hi_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sa_q          <= '0;
         rv_q          <= 1'b0;
         ridx_q        <= '0;
         run_found_q   <= 1'b0;
         run_lo_q      <= '0;
         run_hi_q      <= '0;
         bound_found_q <= 1'b0;
         bound_lo_q    <= '0;
         bound_hi_q    <= '0;
         bound_valid_q <= 1'b0;
         scan_abort_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         sa_q          <= sa_d;
         rv_q          <= rd_issue;
         ridx_q        <= sa_q[COORD_W-1:0];
         bound_valid_q <= scan_last;
         scan_abort_q  <= abort;
         if (state_q == SCAN) begin
            run_found_q <= fin_found;
            run_lo_q    <= fin_lo;
            run_hi_q    <= fin_hi;
         end else begin
            run_found_q <= 1'b0;
            run_lo_q    <= '0;
            run_hi_q    <= '0;
         end
         if (scan_last) begin
            bound_found_q <= fin_found;
            bound_lo_q    <= fin_lo;
            bound_hi_q    <= fin_hi;
         end
      end
   end

   assign bound_lo    = bound_lo_q;
   assign bound_hi    = bound_hi_q;
   assign bound_found = bound_found_q;
   assign bound_valid = bound_valid_q;
   assign scan_abort  = scan_abort_q;

`ifdef VIP_PROJ_PEAK_EN
   logic [COORD_W-1:0] pk_idx_q, fin_pk_idx, peak_idx_q;
   logic [CNT_W-1:0]   pk_cnt_q, fin_pk_cnt, peak_cnt_q;
   logic               pk_take;

   // Strictly-greater comparison keeps the lowest index on a tie.
   assign pk_take    = rv_q && ((ridx_q == '0) || (ram_rdata > pk_cnt_q));
   assign fin_pk_idx = pk_take ? ridx_q    : pk_idx_q;
   assign fin_pk_cnt = pk_take ? ram_rdata : pk_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pk_idx_q   <= '0;
         pk_cnt_q   <= '0;
         peak_idx_q <= '0;
         peak_cnt_q <= '0;
      end else begin
         if (state_q == SCAN) begin
            pk_idx_q <= fin_pk_idx;
            pk_cnt_q <= fin_pk_cnt;
         end else begin
            pk_idx_q <= '0;
            pk_cnt_q <= '0;
         end
         if (scan_last) begin
            peak_idx_q <= fin_pk_idx;
            peak_cnt_q <= fin_pk_cnt;
         end
      end
   end

   assign peak_idx = peak_idx_q;
   assign peak_cnt = peak_cnt_q;
`endif

endmodule
